// File: rtl/axi_xbar_pkg.sv
// Shared encodings and width helpers for the AXI read crossbar.
// Imported by the arbiter and the crossbar top.
package axi_xbar_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_EXOKAY = 2'd1;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    localparam int SIZE_W = 3;

    typedef enum logic [1:0] {
        DS_IDLE,
        DS_ACK,
        DS_DATA
    } ds_state_t;

    function automatic int grant_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int ids_w(input int id_w, input int n_mst);
        return id_w + grant_w(n_mst);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts at ptr, first requester wins.
// Produces both a one-hot grant and the winner index.
module rr_arbiter
    import axi_xbar_pkg::*;
#(
    parameter int N  = 2,
    parameter int GW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [GW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [GW-1:0] idx
);

    logic found;
    int   k;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        k     = 0;
        for (int i = 0; i < N; i++) begin
            k = (int'(ptr) + i) % N;
            if (!found && req[k]) begin
                found  = 1'b1;
                gnt[k] = 1'b1;
                idx    = GW'(k);
            end
        end
    end

endmodule

// File: rtl/axi_rd_xbar.sv
// AXI read-path crossbar: per-target round-robin lock, grant-based
// R routing and an internal DECERR slave for unmapped addresses.
module axi_rd_xbar
    import axi_xbar_pkg::*;
#(
    parameter int N_MST  = 2,
    parameter int N_SLV  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4,
    parameter int LEN_W  = 4,
    parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE = {32'h0001_0000, 32'h0000_0000},
    parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK = {32'hFFFF_0000, 32'hFFFF_0000},
    localparam int IDS_W = ids_w(ID_W, N_MST)
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic [N_MST*ID_W-1:0]     ARID_M,
    input  logic [N_MST*ADDR_W-1:0]   ARADDR_M,
    input  logic [N_MST*LEN_W-1:0]    ARLEN_M,
    input  logic [N_MST*3-1:0]        ARSIZE_M,
    input  logic [N_MST*2-1:0]        ARBURST_M,
    input  logic [N_MST-1:0]          ARVALID_M,
    output logic [N_MST-1:0]          ARREADY_M,
    output logic [N_MST*ID_W-1:0]     RID_M,
    output logic [N_MST*DATA_W-1:0]   RDATA_M,
    output logic [N_MST*2-1:0]        RRESP_M,
    output logic [N_MST-1:0]          RLAST_M,
    output logic [N_MST-1:0]          RVALID_M,
    input  logic [N_MST-1:0]          RREADY_M,
    output logic [N_SLV*IDS_W-1:0]    ARID_S,
    output logic [N_SLV*ADDR_W-1:0]   ARADDR_S,
    output logic [N_SLV*LEN_W-1:0]    ARLEN_S,
    output logic [N_SLV*3-1:0]        ARSIZE_S,
    output logic [N_SLV*2-1:0]        ARBURST_S,
    output logic [N_SLV-1:0]          ARVALID_S,
    input  logic [N_SLV-1:0]          ARREADY_S,
    input  logic [N_SLV*IDS_W-1:0]    RID_S,
    input  logic [N_SLV*DATA_W-1:0]   RDATA_S,
    input  logic [N_SLV*2-1:0]        RRESP_S,
    input  logic [N_SLV-1:0]          RLAST_S,
    input  logic [N_SLV-1:0]          RVALID_S,
    output logic [N_SLV-1:0]          RREADY_S
);

    localparam int T  = N_SLV + 1;
    localparam int GW = grant_w(N_MST);
    localparam int TW = grant_w(T);

    logic [TW-1:0]     tgt [N_MST];
    logic [N_MST-1:0]  outst, m_ar_hs, m_r_end;
    logic [T-1:0]      busy, ar_done, arb_any, ar_hs, r_end;
    logic [GW-1:0]     gnt_q [T];
    logic [GW-1:0]     ptr [T];
    logic [N_MST-1:0]  req [T];
    logic [N_MST-1:0]  arb_oh [T];
    logic [GW-1:0]     arb_idx [T];

    logic [T-1:0]      t_arvalid, t_arready, t_rvalid, t_rlast, t_rready;
    logic [IDS_W-1:0]  t_arid [T];
    logic [LEN_W-1:0]  t_arlen [T];
    logic [IDS_W-1:0]  t_rid [T];
    logic [DATA_W-1:0] t_rdata [T];
    logic [1:0]        t_rresp [T];

    ds_state_t         ds_q, ds_d;
    logic [IDS_W-1:0]  ds_id;
    logic [LEN_W-1:0]  ds_len, ds_cnt;
    logic              ds_arready, ds_rvalid, ds_rlast;

    // Lowest matching slave wins; no match falls through to the DECERR slave.
    always_comb begin
        for (int m = 0; m < N_MST; m++) begin
            tgt[m] = TW'(N_SLV);
            for (int s = N_SLV - 1; s >= 0; s--) begin
                if ((ARADDR_M[m*ADDR_W +: ADDR_W] & SLV_MASK[s*ADDR_W +: ADDR_W])
                    == SLV_BASE[s*ADDR_W +: ADDR_W])
                    tgt[m] = TW'(s);
            end
        end
        for (int t = 0; t < T; t++) begin
            for (int m = 0; m < N_MST; m++)
                req[t][m] = ARVALID_M[m] & ~outst[m] & (tgt[m] == TW'(t));
        end
    end

    for (genvar t = 0; t < T; t++) begin : g_arb
        rr_arbiter #(.N(N_MST), .GW(GW)) u_arb (
            .req (req[t]),
            .ptr (ptr[t]),
            .gnt (arb_oh[t]),
            .idx (arb_idx[t])
        );
        assign arb_any[t] = |arb_oh[t];
    end

    always_comb begin
        t_arvalid = '0;
        t_rready  = '0;
        ARID_S    = '0;
        ARADDR_S  = '0;
        ARLEN_S   = '0;
        ARSIZE_S  = '0;
        ARBURST_S = '0;
        for (int t = 0; t < T; t++) begin
            t_arid[t]  = '0;
            t_arlen[t] = '0;
            for (int m = 0; m < N_MST; m++) begin
                if (busy[t] && gnt_q[t] == GW'(m)) begin
                    t_arvalid[t] = ~ar_done[t] & ARVALID_M[m];
                    t_rready[t]  = RREADY_M[m];
                    if (!ar_done[t]) begin
                        t_arid[t]  = {GW'(m), ARID_M[m*ID_W +: ID_W]};
                        t_arlen[t] = ARLEN_M[m*LEN_W +: LEN_W];
                    end
                end
            end
        end
        for (int s = 0; s < N_SLV; s++) begin
            ARID_S[s*IDS_W +: IDS_W] = t_arid[s];
            ARLEN_S[s*LEN_W +: LEN_W] = t_arlen[s];
            for (int m = 0; m < N_MST; m++) begin
                if (busy[s] && !ar_done[s] && gnt_q[s] == GW'(m)) begin
                    ARADDR_S[s*ADDR_W +: ADDR_W] = ARADDR_M[m*ADDR_W +: ADDR_W];
                    ARSIZE_S[s*3 +: 3]  = ARSIZE_M[m*3 +: 3];
                    ARBURST_S[s*2 +: 2] = ARBURST_M[m*2 +: 2];
                end
            end
        end
    end

    assign ARVALID_S = t_arvalid[N_SLV-1:0];
    assign RREADY_S  = t_rready[N_SLV-1:0];
    assign t_arready = {ds_arready, ARREADY_S};
    assign t_rvalid  = {ds_rvalid, RVALID_S};
    assign t_rlast   = {ds_rlast, RLAST_S};

    always_comb begin
        for (int s = 0; s < N_SLV; s++) begin
            t_rid[s]   = RID_S[s*IDS_W +: IDS_W];
            t_rdata[s] = RDATA_S[s*DATA_W +: DATA_W];
            t_rresp[s] = RRESP_S[s*2 +: 2];
        end
        t_rid[N_SLV]   = ds_id;
        t_rdata[N_SLV] = '0;
        t_rresp[N_SLV] = RESP_DECERR;
    end

    // R is steered by the registered grant, never by the returned ID.
    always_comb begin
        ARREADY_M = '0;
        RID_M     = '0;
        RDATA_M   = '0;
        RRESP_M   = '0;
        RLAST_M   = '0;
        RVALID_M  = '0;
        for (int m = 0; m < N_MST; m++) begin
            for (int t = 0; t < T; t++) begin
                if (busy[t] && gnt_q[t] == GW'(m)) begin
                    ARREADY_M[m] = ~ar_done[t] & t_arready[t];
                    RVALID_M[m]  = t_rvalid[t];
                    RLAST_M[m]   = t_rlast[t];
                    RID_M[m*ID_W +: ID_W]     = t_rid[t][ID_W-1:0];
                    RDATA_M[m*DATA_W +: DATA_W] = t_rdata[t];
                    RRESP_M[m*2 +: 2]         = t_rresp[t];
                end
            end
        end
    end

    assign ar_hs   = t_arvalid & t_arready;
    assign r_end   = busy & t_rvalid & t_rready & t_rlast;
    assign m_ar_hs = ARVALID_M & ARREADY_M;
    assign m_r_end = RVALID_M & RREADY_M & RLAST_M;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            busy    <= '0;
            ar_done <= '0;
            outst   <= '0;
            for (int t = 0; t < T; t++) begin
                gnt_q[t] <= '0;
                ptr[t]   <= '0;
            end
        end else begin
            outst <= (outst | m_ar_hs) & ~m_r_end;
            for (int t = 0; t < T; t++) begin
                if (!busy[t]) begin
                    if (arb_any[t]) begin
                        busy[t]    <= 1'b1;
                        ar_done[t] <= 1'b0;
                        gnt_q[t]   <= arb_idx[t];
                    end
                end else begin
                    if (ar_hs[t]) begin
                        ar_done[t] <= 1'b1;
                        ptr[t] <= (gnt_q[t] == GW'(N_MST - 1)) ? '0 : gnt_q[t] + GW'(1);
                    end
                    if (r_end[t]) begin
                        busy[t]    <= 1'b0;
                        ar_done[t] <= 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            ds_q   <= DS_IDLE;
            ds_id  <= '0;
            ds_len <= '0;
            ds_cnt <= '0;
        end else begin
            ds_q <= ds_d;
            if (ds_q == DS_ACK) begin
                ds_id  <= t_arid[N_SLV];
                ds_len <= t_arlen[N_SLV];
                ds_cnt <= '0;
            end else if (ds_q == DS_DATA && t_rready[N_SLV]) begin
                ds_cnt <= ds_cnt + LEN_W'(1);
            end
        end
    end

    always_comb begin
        ds_d       = ds_q;
        ds_arready = 1'b0;
        ds_rvalid  = 1'b0;
        ds_rlast   = 1'b0;
        unique case (ds_q)
            DS_IDLE: if (t_arvalid[N_SLV]) ds_d = DS_ACK;
            DS_ACK: begin
                ds_arready = 1'b1;
                ds_d       = DS_DATA;
            end
            DS_DATA: begin
                ds_rvalid = 1'b1;
                ds_rlast  = (ds_cnt == ds_len);
                if (t_rready[N_SLV] && ds_rlast) ds_d = DS_IDLE;
            end
            default: ds_d = DS_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_rd_xbar.sv
// Directed bench for axi_rd_xbar with two simple streaming slaves.
// Slave s returns beat b as 32'hD000_0000 + s*256 + b.
module tb_axi_rd_xbar;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  ARID_M = '0;
    logic [63:0] ARADDR_M = '0;
    logic [7:0]  ARLEN_M = '0;
    logic [5:0]  ARSIZE_M = '0;
    logic [3:0]  ARBURST_M = '0;
    logic [1:0]  ARVALID_M = '0;
    logic [1:0]  ARREADY_M;
    logic [7:0]  RID_M;
    logic [63:0] RDATA_M;
    logic [3:0]  RRESP_M;
    logic [1:0]  RLAST_M, RVALID_M;
    logic [1:0]  RREADY_M = '0;
    logic [9:0]  ARID_S;
    logic [63:0] ARADDR_S;
    logic [7:0]  ARLEN_S;
    logic [5:0]  ARSIZE_S;
    logic [3:0]  ARBURST_S;
    logic [1:0]  ARVALID_S;
    wire  [1:0]  ARREADY_S;
    wire  [9:0]  RID_S;
    wire  [63:0] RDATA_S;
    wire  [3:0]  RRESP_S;
    wire  [1:0]  RLAST_S, RVALID_S;
    logic [1:0]  RREADY_S;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    axi_rd_xbar dut (
        .ACLK(clk), .ARESET(rst),
        .ARID_M(ARID_M), .ARADDR_M(ARADDR_M), .ARLEN_M(ARLEN_M),
        .ARSIZE_M(ARSIZE_M), .ARBURST_M(ARBURST_M),
        .ARVALID_M(ARVALID_M), .ARREADY_M(ARREADY_M),
        .RID_M(RID_M), .RDATA_M(RDATA_M), .RRESP_M(RRESP_M),
        .RLAST_M(RLAST_M), .RVALID_M(RVALID_M), .RREADY_M(RREADY_M),
        .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S),
        .ARSIZE_S(ARSIZE_S), .ARBURST_S(ARBURST_S),
        .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
        .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S),
        .RLAST_S(RLAST_S), .RVALID_S(RVALID_S), .RREADY_S(RREADY_S)
    );

    for (genvar s = 0; s < 2; s++) begin : g_slv
        logic       busy;
        logic [4:0] id;
        logic [3:0] len, cnt;
        assign ARREADY_S[s]       = ~busy;
        assign RVALID_S[s]        = busy;
        assign RID_S[s*5 +: 5]    = id;
        assign RDATA_S[s*32 +: 32] = 32'hD000_0000 + 32'(s * 256) + 32'(cnt);
        assign RRESP_S[s*2 +: 2]  = 2'b00;
        assign RLAST_S[s]         = busy & (cnt == len);
        always @(posedge clk or posedge rst) begin
            if (rst) begin
                busy <= 1'b0; id <= '0; len <= '0; cnt <= '0;
            end else if (!busy) begin
                if (ARVALID_S[s]) begin
                    busy <= 1'b1;
                    id   <= ARID_S[s*5 +: 5];
                    len  <= ARLEN_S[s*4 +: 4];
                    cnt  <= '0;
                end
            end else if (RREADY_S[s]) begin
                if (cnt == len) busy <= 1'b0;
                else cnt <= cnt + 4'd1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, o, e);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic ar(input int m, input logic v, input logic [31:0] a,
                      input logic [3:0] id, input logic [3:0] len);
        ARVALID_M[m]         = v;
        ARADDR_M[m*32 +: 32] = a;
        ARID_M[m*4 +: 4]     = id;
        ARLEN_M[m*4 +: 4]    = len;
        ARSIZE_M[m*3 +: 3]   = 3'd2;
        ARBURST_M[m*2 +: 2]  = 2'b01;
    endtask

    task automatic beat(input string tag, input int m, input logic [31:0] d,
                        input logic [1:0] r, input logic [3:0] id, input logic last);
        chk({tag, "_v"}, 64'(RVALID_M[m]), 64'd1);
        chk({tag, "_d"}, 64'(RDATA_M[m*32 +: 32]), 64'(d));
        chk({tag, "_r"}, 64'(RRESP_M[m*2 +: 2]), 64'(r));
        chk({tag, "_id"}, 64'(RID_M[m*4 +: 4]), 64'(id));
        chk({tag, "_l"}, 64'(RLAST_M[m]), 64'(last));
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_arready", 64'(ARREADY_M), 64'd0);
        chk("rst_rvalid", 64'(RVALID_M), 64'd0);
        chk("rst_arvalid_s", 64'(ARVALID_S), 64'd0);
        chk("rst_rdata", RDATA_M, 64'd0);
        rst = 1'b0;
        RREADY_M = 2'b11;

        // single burst on S0
        ar(0, 1'b1, 32'h0000_0010, 4'h5, 4'd3);
        #1 chk("t1_lat0", 64'(ARVALID_S[0]), 64'd0);
        tick();
        chk("t1_arv", 64'(ARVALID_S[0]), 64'd1);
        chk("t1_arid", 64'(ARID_S[4:0]), 64'h05);
        chk("t1_addr", 64'(ARADDR_S[31:0]), 64'h10);
        chk("t1_len", 64'(ARLEN_S[3:0]), 64'd3);
        chk("t1_ardy", 64'(ARREADY_M), 64'b01);
        tick();
        ar(0, 1'b0, '0, '0, '0);
        for (int b = 0; b < 4; b++) begin
            beat("t1_b", 0, 32'hD000_0000 + 32'(b), 2'b00, 4'h5, b == 3);
            tick();
        end
        chk("t1_idle_v", 64'(RVALID_M), 64'd0);
        chk("t1_idle_d", 64'(RDATA_M[31:0]), 64'd0);

        // contention on S1
        ar(0, 1'b1, 32'h0001_0000, 4'h2, 4'd1);
        ar(1, 1'b1, 32'h0001_0000, 4'h7, 4'd1);
        tick();
        chk("t2_arv", 64'(ARVALID_S), 64'b10);
        chk("t2_arid0", 64'(ARID_S[9:5]), 64'h02);
        chk("t2_ardy0", 64'(ARREADY_M), 64'b01);
        tick();
        ar(0, 1'b0, '0, '0, '0);
        beat("t2_m0b0", 0, 32'hD000_0100, 2'b00, 4'h2, 1'b0);
        chk("t2_m1_norv", 64'(RVALID_M[1]), 64'd0);
        tick();
        beat("t2_m0b1", 0, 32'hD000_0101, 2'b00, 4'h2, 1'b1);
        tick();
        ar(0, 1'b1, 32'h0001_0004, 4'h3, 4'd0);
        #1 chk("t2_gap", 64'(ARVALID_S[1]), 64'd0);
        tick();
        chk("t2_arid1", 64'(ARID_S[9:5]), 64'h17);
        chk("t2_ardy1", 64'(ARREADY_M), 64'b10);
        tick();
        ar(1, 1'b0, '0, '0, '0);
        beat("t2_m1b0", 1, 32'hD000_0100, 2'b00, 4'h7, 1'b0);
        tick();
        beat("t2_m1b1", 1, 32'hD000_0101, 2'b00, 4'h7, 1'b1);
        tick();
        tick();
        chk("t2_arid2", 64'(ARID_S[9:5]), 64'h03);
        chk("t2_ardy2", 64'(ARREADY_M), 64'b01);
        tick();
        ar(0, 1'b0, '0, '0, '0);
        beat("t2_m0c", 0, 32'hD000_0100, 2'b00, 4'h3, 1'b1);
        tick();

        // concurrent S0 / S1
        ar(0, 1'b1, 32'h0000_0020, 4'h1, 4'd1);
        ar(1, 1'b1, 32'h0001_0040, 4'h4, 4'd2);
        tick();
        chk("t3_arv", 64'(ARVALID_S), 64'b11);
        chk("t3_arid0", 64'(ARID_S[4:0]), 64'h01);
        chk("t3_arid1", 64'(ARID_S[9:5]), 64'h14);
        chk("t3_ardy", 64'(ARREADY_M), 64'b11);
        tick();
        ar(0, 1'b0, '0, '0, '0);
        ar(1, 1'b0, '0, '0, '0);
        for (int b = 0; b < 3; b++) begin
            if (b < 2) beat("t3_m0", 0, 32'hD000_0000 + 32'(b), 2'b00, 4'h1, b == 1);
            else chk("t3_m0_done", 64'(RVALID_M[0]), 64'd0);
            beat("t3_m1", 1, 32'hD000_0100 + 32'(b), 2'b00, 4'h4, b == 2);
            tick();
        end

        // unmapped address -> DECERR
        ar(1, 1'b1, 32'h8000_0000, 4'h9, 4'd2);
        tick();
        chk("t4_no_ext", 64'(ARVALID_S), 64'd0);
        chk("t4_ardy_lo", 64'(ARREADY_M[1]), 64'd0);
        tick();
        chk("t4_ardy_hi", 64'(ARREADY_M[1]), 64'd1);
        tick();
        ar(1, 1'b0, '0, '0, '0);
        for (int b = 0; b < 3; b++) begin
            beat("t4_b", 1, 32'h0, 2'b11, 4'h9, b == 2);
            tick();
        end
        chk("t4_idle_v", 64'(RVALID_M[1]), 64'd0);
        chk("t4_idle_r", 64'(RRESP_M[3:2]), 64'd0);

        // backpressure
        ar(0, 1'b1, 32'h0000_0000, 4'h6, 4'd3);
        tick();
        chk("t5_ardy", 64'(ARREADY_M[0]), 64'd1);
        tick();
        ar(0, 1'b0, '0, '0, '0);
        beat("t5_b0", 0, 32'hD000_0000, 2'b00, 4'h6, 1'b0);
        tick();
        RREADY_M[0] = 1'b0;
        #1 chk("t5_rr_lo", 64'(RREADY_S[0]), 64'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_hold_v", 64'(RVALID_M[0]), 64'd1);
            chk("t5_hold_d", 64'(RDATA_M[31:0]), 64'hD000_0001);
            chk("t5_hold_rr", 64'(RREADY_S[0]), 64'd0);
        end
        RREADY_M[0] = 1'b1;
        #1 chk("t5_rr_hi", 64'(RREADY_S[0]), 64'd1);
        for (int b = 1; b < 4; b++) begin
            beat("t5_b", 0, 32'hD000_0000 + 32'(b), 2'b00, 4'h6, b == 3);
            tick();
        end
        chk("t5_idle", 64'(RVALID_M[0]), 64'd0);

        // reset in mid-burst
        ar(0, 1'b1, 32'h0000_0040, 4'hA, 4'd3);
        tick();
        tick();
        ar(0, 1'b0, '0, '0, '0);
        beat("t6_b0", 0, 32'hD000_0000, 2'b00, 4'hA, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("t6_rv", 64'(RVALID_M), 64'd0);
        chk("t6_rd", RDATA_M, 64'd0);
        chk("t6_arv", 64'(ARVALID_S), 64'd0);
        chk("t6_rrs", 64'(RREADY_S), 64'd0);
        chk("t6_ardy", 64'(ARREADY_M), 64'd0);
        repeat (2) tick();
        rst = 1'b0;
        ar(0, 1'b1, 32'h0000_0000, 4'h1, 4'd0);
        ar(1, 1'b1, 32'h0000_0004, 4'h2, 4'd0);
        tick();
        chk("t6_arid_a", 64'(ARID_S[4:0]), 64'h01);
        chk("t6_ardy_a", 64'(ARREADY_M), 64'b01);
        tick();
        ar(0, 1'b0, '0, '0, '0);
        beat("t6_m0", 0, 32'hD000_0000, 2'b00, 4'h1, 1'b1);
        tick();
        tick();
        chk("t6_arid_b", 64'(ARID_S[4:0]), 64'h12);
        chk("t6_ardy_b", 64'(ARREADY_M), 64'b10);
        tick();
        ar(1, 1'b0, '0, '0, '0);
        beat("t6_m1", 1, 32'hD000_0000, 2'b00, 4'h2, 1'b1);
        tick();
        chk("t6_idle", 64'(RVALID_M), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_rd_xbar.md
Name: axi_rd_xbar

Overview:
Parametrised AXI read-path crossbar (AR + R channels) for N_MST masters and N_SLV slaves.
- Replaces the fixed 2x2 shared-access read path with per-slave round-robin arbitration and base/mask address decode.
- Includes an internal default slave that returns DECERR for unmapped addresses.
- Transfers to different slaves proceed concurrently; each master has at most one outstanding read.

Parameters:
N_MST, 2, number of masters (>=1)
N_SLV, 2, number of external slaves (>=1)
ADDR_W, 32, address width
DATA_W, 32, data width
ID_W, 4, master-side ID width; slave-side IDS_W = ID_W + max(1,$clog2(N_MST)) (derived localparam)
LEN_W, 4, burst length width
SLV_BASE, {32'h0001_0000, 32'h0000_0000}, packed N_SLV*ADDR_W base addresses; slave s occupies [s*ADDR_W +: ADDR_W]
SLV_MASK, {32'hFFFF_0000, 32'hFFFF_0000}, packed N_SLV*ADDR_W decode masks; slave s occupies [s*ADDR_W +: ADDR_W]

Ports:
ACLK  in  1  clock
ARESET  in  1  asynchronous reset, active-high
ARID_M  in  N_MST*ID_W  master AR ID
ARADDR_M  in  N_MST*ADDR_W  master AR address
ARLEN_M  in  N_MST*LEN_W  master AR length
ARSIZE_M  in  N_MST*3  master AR size
ARBURST_M  in  N_MST*2  master AR burst
ARVALID_M  in  N_MST  master AR valid
ARREADY_M  out  N_MST  master AR ready
RID_M  out  N_MST*ID_W  master R ID
RDATA_M  out  N_MST*DATA_W  master R data
RRESP_M  out  N_MST*2  master R response
RLAST_M  out  N_MST  master R last
RVALID_M  out  N_MST  master R valid
RREADY_M  in  N_MST  master R ready
ARID_S  out  N_SLV*IDS_W  slave AR ID
ARADDR_S  out  N_SLV*ADDR_W  slave AR address
ARLEN_S  out  N_SLV*LEN_W  slave AR length
ARSIZE_S  out  N_SLV*3  slave AR size
ARBURST_S  out  N_SLV*2  slave AR burst
ARVALID_S  out  N_SLV  slave AR valid
ARREADY_S  in  N_SLV  slave AR ready
RID_S  in  N_SLV*IDS_W  slave R ID
RDATA_S  in  N_SLV*DATA_W  slave R data
RRESP_S  in  N_SLV*2  slave R response
RLAST_S  in  N_SLV  slave R last
RVALID_S  in  N_SLV  slave R valid
RREADY_S  out  N_SLV  slave R ready

Behaviour:
- Reset (async, ARESET=1): all outputs 0; grant registers cleared; round-robin pointers = 0; default slave returns to IDLE.
- Reset mid-burst: transaction is abandoned and no completion is generated. External slaves share the reset.
- Decode (combinational on ARADDR_M): target = lowest s with (ARADDR & SLV_MASK[s]) == SLV_BASE[s]. No match selects the internal default slave (index N_SLV).
- Each target (N_SLV+1 in total) has a FREE/BUSY lock and a registered grant index.
- Arbitration, cycle N: in a FREE target, round-robin is performed among masters with ARVALID=1, decode hitting that target, and no outstanding read.
  - Search starts at the pointer; the winner is registered.
  - In cycle N+1 the target becomes BUSY and ARVALID_S asserts. AR latency is 1 cycle.
- AR forwarding while BUSY and AR not yet accepted:
  - ARVALID_S = ARVALID_M[g]; address, length, size and burst are passed through.
  - ARID_S = {g, ARID_M[g]}.
  - ARREADY_M[g] = ARREADY_S. All other masters see ARREADY=0.
  - On the AR handshake, the pointer becomes (g+1) mod N_MST.
- R routing while BUSY, by grant (not by ID):
  - RVALID_M[g], RDATA, RRESP and RLAST come from the slave.
  - RID_M[g] = low ID_W bits of RID_S.
  - RREADY_S = RREADY_M[g].
- Release: the handshake with RVALID & RREADY & RLAST returns the target to FREE on the next edge. Same-cycle regrant is not allowed.
- Per-master outstanding flag:
  - Set on the AR handshake; cleared on the RLAST handshake.
  - A master in this state is excluded from arbitration.
- Two or more masters completing on different slaves in the same cycle are independent and must not interfere.
- Idle outputs: any master with no routed R drives RVALID=0, RDATA=0 and RRESP=0.
- Default slave FSM: IDLE -> ACK -> DATA -> IDLE.
  - IDLE: waits for ARVALID.
  - ACK: ARREADY=1 for one cycle; ID and length are latched.
  - DATA: returns ARLEN+1 beats with RDATA=0, RRESP=2'b11 (DECERR), RID echoed, and RLAST on the final beat.
  - A beat counter advances only on RVALID&RREADY.
- Master ARVALID and payload must stay stable until ARREADY. The bench checks this; the block does not.

Decomposition:
- Package axi_xbar_pkg: resp encodings (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3), burst encodings, IDS_W/grant-width functions, size field width.
- Sub-module rr_arbiter: parametrised N-request round-robin with pointer input and one-hot/index grant output; instantiated N_SLV+1 times.
- The default slave is an internal always block; it is not a separate module.

Test Plan:
- M0 reads 0x0000_0010 with len=3 while S0 streams beats D0..D3 -> ARVALID_S0 rises 1 cycle after ARVALID_M0; ARID_S0={0,ARID}; M0 receives 4 beats with RLAST on the 4th; S0 is free 1 cycle after the last beat.
- M0 and M1 both request S1 (0x0001_0000) in the same cycle, pointer=0 -> M0 is granted first and M1 after M0's RLAST+1; next contention grants M1 first.
- M0 targets S0 while M1 targets S1 in the same cycle -> both ARVALID_S assert in the same cycle; both bursts complete concurrently with correct routing.
- M1 reads 0x8000_0000 with len=2 -> 3 beats with RDATA=0, RRESP=2'b11, RID echoed, RLAST on beat 3.
- RREADY_M0 held low for 5 cycles mid-burst -> RREADY_S0=0, no beat is lost, and data order is preserved.
- ARESET asserted mid-burst on S0 -> all outputs go to 0 asynchronously; after release a fresh read completes normally with pointers at 0.
